// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller.
// Contents: state encoding (doubles as the user-visible y_out code),
// BCD digit range, PIN/amount field widths and small decode helpers.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_PIN      = 3'b001,
        ST_MENU     = 3'b010,
        ST_AMOUNT   = 3'b011,
        ST_DISPENSE = 3'b100,
        ST_EJECT    = 3'b101,
        ST_LOCKED   = 3'b111
    } state_t;

    localparam logic [3:0] DIGIT_MAX  = 4'd9;
    localparam int         BCD_W      = 4;
    localparam int         PIN_DIGITS = 4;
    localparam int         PIN_W      = PIN_DIGITS * BCD_W;
    localparam int         AMT_DIGITS = 3;
    localparam int         AMT_W      = 10;
    localparam int         BAL_W      = 16;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= DIGIT_MAX;
    endfunction

    // States in which the customer is interacting and the idle timer runs.
    function automatic logic in_session(input state_t s);
        return (s == ST_PIN) || (s == ST_MENU) || (s == ST_AMOUNT);
    endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// Idle timer for the ATM session controller.
// Down-counter with terminal-count compare. expired asserts on the
// TIMEOUT_CYC-th consecutive cycle of a quiet session: the cycle in which
// clear is high counts as the first, so the reload value is TIMEOUT_CYC-2.
// Ports:
//   clock   in  system clock
//   reset   in  asynchronous active-high reset
//   clear   in  reload the counter (strobe, state change or out of session)
//   enable  in  session active, counter may run
//   expired out terminal count reached this cycle
module atm_idle_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYC - 2);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = enable && !clear && (cnt == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card-in, PIN check with lockout, menu, amount entry
// with limit/balance check, dispense handshake and card eject.
// Ports:
//   clock, reset                 clock and async active-high reset
//   card_in                      card present level
//   key_valid/key_code           digit strobe and code (0-9, others ignored)
//   key_enter, key_cancel        confirm / abort strobes
//   dispense_ack                 dispenser done
//   y_out                        state code shown to the user
//   y_out_flash                  error pulse / lock indicator
//   dispense_valid, dispense_amt dispense request and amount
//   balance                      current balance
//   card_eject                   eject request
//
// state    | meaning
// IDLE     | no card, waiting for insertion
// PIN      | collecting 4 PIN digits
// MENU     | PIN accepted, waiting for selection
// AMOUNT   | collecting up to 3 amount digits
// DISPENSE | request held until dispenser acknowledges
// EJECT    | card pushed out until removed
// LOCKED   | too many wrong PINs, card retained until reset
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter logic [15:0] PIN_CODE     = 16'h1234,
    parameter int          MAX_TRIES    = 3,
    parameter logic [15:0] INIT_BALANCE = 16'd1000,
    parameter logic [9:0]  MAX_WD       = 10'd500,
    parameter int          TIMEOUT_CYC  = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        card_in,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        key_enter,
    input  logic        key_cancel,
    input  logic        dispense_ack,
    output logic [2:0]  y_out,
    output logic        y_out_flash,
    output logic        dispense_valid,
    output logic [9:0]  dispense_amt,
    output logic [15:0] balance,
    output logic        card_eject
);

    localparam logic [2:0] TRIES_LIMIT = 3'(MAX_TRIES);

    state_t           state;
    state_t           prev_state;
    logic [PIN_W-1:0] pin_reg;
    logic [2:0]       pin_cnt;
    logic [2:0]       tries;
    logic [AMT_W-1:0] amount;
    logic [1:0]       amt_cnt;
    logic             expired;
    logic             key_digit;
    logic             amt_bad;

    assign key_digit = key_valid && is_digit(key_code);
    assign amt_bad   = (amount == '0) || (amount > MAX_WD) ||
                       ({6'd0, amount} > balance);

    atm_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_idle_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (key_valid || key_enter || key_cancel ||
                  (state != prev_state) || !in_session(state)),
        .enable  (in_session(state)),
        .expired (expired)
    );

    assign y_out = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            prev_state     <= ST_IDLE;
            pin_reg        <= '0;
            pin_cnt        <= '0;
            tries          <= '0;
            amount         <= '0;
            amt_cnt        <= '0;
            balance        <= INIT_BALANCE;
            dispense_amt   <= '0;
            dispense_valid <= 1'b0;
            card_eject     <= 1'b0;
            y_out_flash    <= 1'b0;
        end else begin
            prev_state  <= state;
            y_out_flash <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (card_in) begin
                        state   <= ST_PIN;
                        pin_reg <= '0;
                        pin_cnt <= '0;
                        tries   <= '0;
                    end
                end
                ST_PIN: begin
                    // Card removal wins over everything: nothing left to eject.
                    if (!card_in) begin
                        state <= ST_IDLE;
                    end else if (key_cancel || expired) begin
                        state      <= ST_EJECT;
                        card_eject <= 1'b1;
                    end else if (key_enter) begin
                        if (pin_cnt == 3'(PIN_DIGITS)) begin
                            pin_reg <= '0;
                            pin_cnt <= '0;
                            if (pin_reg == PIN_CODE) begin
                                state <= ST_MENU;
                                tries <= '0;
                            end else begin
                                tries       <= tries + 3'd1;
                                y_out_flash <= 1'b1;
                                if (tries + 3'd1 == TRIES_LIMIT) begin
                                    state <= ST_LOCKED;
                                end
                            end
                        end
                    end else if (key_digit && (pin_cnt != 3'(PIN_DIGITS))) begin
                        pin_reg <= {pin_reg[PIN_W-BCD_W-1:0], key_code};
                        pin_cnt <= pin_cnt + 3'd1;
                    end
                end
                ST_MENU: begin
                    if (!card_in) begin
                        state <= ST_IDLE;
                    end else if (key_cancel || expired) begin
                        state      <= ST_EJECT;
                        card_eject <= 1'b1;
                    end else if (key_valid && (key_code == 4'd1) && !key_enter) begin
                        state   <= ST_AMOUNT;
                        amount  <= '0;
                        amt_cnt <= '0;
                    end
                end
                ST_AMOUNT: begin
                    if (!card_in) begin
                        state <= ST_IDLE;
                    end else if (key_cancel || expired) begin
                        state      <= ST_EJECT;
                        card_eject <= 1'b1;
                    end else if (key_enter) begin
                        amount  <= '0;
                        amt_cnt <= '0;
                        if (amt_bad) begin
                            y_out_flash <= 1'b1;
                        end else begin
                            state          <= ST_DISPENSE;
                            balance        <= balance - {6'd0, amount};
                            dispense_amt   <= amount;
                            dispense_valid <= 1'b1;
                        end
                    end else if (key_digit && (amt_cnt != 2'(AMT_DIGITS))) begin
                        amount  <= amount * 10'd10 + {6'd0, key_code};
                        amt_cnt <= amt_cnt + 2'd1;
                    end
                end
                ST_DISPENSE: begin
                    if (dispense_ack) begin
                        state          <= ST_EJECT;
                        dispense_valid <= 1'b0;
                        card_eject     <= 1'b1;
                    end
                end
                ST_EJECT: begin
                    if (!card_in) begin
                        state      <= ST_IDLE;
                        card_eject <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    y_out_flash <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboard bench for atm_session_ctrl: stimulus pushes the expected output
// snapshot for every output change; the monitor pops one entry per observed change.
module tb_atm_session_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        card_in = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        key_enter = 1'b0;
    logic        key_cancel = 1'b0;
    logic        dispense_ack = 1'b0;
    logic [2:0]  y_out;
    logic        y_out_flash;
    logic        dispense_valid;
    logic [9:0]  dispense_amt;
    logic [15:0] balance;
    logic        card_eject;

    atm_session_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .card_in        (card_in),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_enter      (key_enter),
        .key_cancel     (key_cancel),
        .dispense_ack   (dispense_ack),
        .y_out          (y_out),
        .y_out_flash    (y_out_flash),
        .dispense_valid (dispense_valid),
        .dispense_amt   (dispense_amt),
        .balance        (balance),
        .card_eject     (card_eject)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  y;
        logic        f;
        logic        dv;
        logic [9:0]  amt;
        logic [15:0] bal;
        logic        ej;
    } snap_t;

    typedef struct {
        string name;
        snap_t s;
        int    cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Monitor: one comparison per change of the observable output set.
    initial begin
        snap_t cur;
        snap_t last;
        bit    have_last;
        exp_t  e;
        have_last = 0;
        last = '0;
        forever begin
            @(negedge clock);
            cur = '{y: y_out, f: y_out_flash, dv: dispense_valid, amt: dispense_amt,
                    bal: balance, ej: card_eject};
            if (!have_last || cur != last) begin
                have_last = 1;
                last = cur;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got y=%0d f=%0b dv=%0b amt=%0d bal=%0d ej=%0b at cyc %0d, none expected",
                             cur.y, cur.f, cur.dv, cur.amt, cur.bal, cur.ej, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e.s || (e.cyc >= 0 && e.cyc != cyc)) begin
                        errors++;
                        $display("FAIL %s: got y=%0d f=%0b dv=%0b amt=%0d bal=%0d ej=%0b cyc=%0d, expected y=%0d f=%0b dv=%0b amt=%0d bal=%0d ej=%0b cyc=%0d",
                                 e.name, cur.y, cur.f, cur.dv, cur.amt, cur.bal, cur.ej, cyc,
                                 e.s.y, e.s.f, e.s.dv, e.s.amt, e.s.bal, e.s.ej, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    task automatic want(input string n, input logic [2:0] y, input logic f, input logic dv,
                        input logic [9:0] amt, input logic [15:0] bal, input logic ej,
                        input int c = -1);
        exp_t e;
        e.name = n;
        e.s = '{y: y, f: f, dv: dv, amt: amt, bal: bal, ej: ej};
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code = c;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic cancel();
        key_cancel = 1'b1;
        tick();
        key_cancel = 1'b0;
    endtask

    task automatic keys4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    task automatic ack();
        dispense_ack = 1'b1;
        tick();
        dispense_ack = 1'b0;
    endtask

    initial begin
        want("reset_state", 3'd0, 0, 0, 10'd0, 16'd1000, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Happy path: withdraw 200.
        want("t2_pin", 3'd1, 0, 0, 10'd0, 16'd1000, 0);
        card_in = 1'b1; tick();
        want("t2_menu", 3'd2, 0, 0, 10'd0, 16'd1000, 0);
        keys4(1, 2, 3, 4); enter();
        want("t2_amount", 3'd3, 0, 0, 10'd0, 16'd1000, 0);
        key(1);
        key(2); key(0); key(0);
        want("t2_dispense", 3'd4, 0, 1, 10'd200, 16'd800, 0);
        enter();
        repeat (2) tick();
        want("t2_eject", 3'd5, 0, 0, 10'd200, 16'd800, 1);
        ack();
        want("t2_idle", 3'd0, 0, 0, 10'd200, 16'd800, 0);
        card_in = 1'b0; tick();

        // Amount rejections, then 4th digit ignored (100).
        want("t4_pin", 3'd1, 0, 0, 10'd200, 16'd800, 0);
        card_in = 1'b1; tick();
        want("t4_menu", 3'd2, 0, 0, 10'd200, 16'd800, 0);
        keys4(1, 2, 3, 4); enter();
        want("t4_amount", 3'd3, 0, 0, 10'd200, 16'd800, 0);
        key(1);
        key(6); key(0); key(0);
        want("t4_600_flash", 3'd3, 1, 0, 10'd200, 16'd800, 0);
        want("t4_600_clear", 3'd3, 0, 0, 10'd200, 16'd800, 0);
        enter(); tick();
        want("t4_zero_flash", 3'd3, 1, 0, 10'd200, 16'd800, 0);
        want("t4_zero_clear", 3'd3, 0, 0, 10'd200, 16'd800, 0);
        enter(); tick();
        keys4(1, 0, 0, 5);
        want("t4_dispense100", 3'd4, 0, 1, 10'd100, 16'd700, 0);
        enter();
        want("t4_eject", 3'd5, 0, 0, 10'd100, 16'd700, 1);
        ack();
        want("t4_idle", 3'd0, 0, 0, 10'd100, 16'd700, 0);
        card_in = 1'b0; tick();

        // Short PIN enter ignored, 5th digit ignored, menu 2 stays, cancel.
        want("pb_pin", 3'd1, 0, 0, 10'd100, 16'd700, 0);
        card_in = 1'b1; tick();
        key(1); key(2); enter();
        key(3); key(4); key(9);
        want("pb_menu", 3'd2, 0, 0, 10'd100, 16'd700, 0);
        enter();
        key(2); tick();
        want("pb_amount", 3'd3, 0, 0, 10'd100, 16'd700, 0);
        key(1);
        want("pb_cancel_eject", 3'd5, 0, 0, 10'd100, 16'd700, 1);
        cancel();
        want("pb_idle", 3'd0, 0, 0, 10'd100, 16'd700, 0);
        card_in = 1'b0; tick();

        // Cancel beats key_valid in MENU.
        want("t5a_pin", 3'd1, 0, 0, 10'd100, 16'd700, 0);
        card_in = 1'b1; tick();
        want("t5a_menu", 3'd2, 0, 0, 10'd100, 16'd700, 0);
        keys4(1, 2, 3, 4); enter();
        want("t5a_eject", 3'd5, 0, 0, 10'd100, 16'd700, 1);
        key_cancel = 1'b1; key(1); key_cancel = 1'b0;
        want("t5a_idle", 3'd0, 0, 0, 10'd100, 16'd700, 0);
        card_in = 1'b0; tick();

        // Card pulled during AMOUNT.
        want("t6_pin", 3'd1, 0, 0, 10'd100, 16'd700, 0);
        card_in = 1'b1; tick();
        want("t6_menu", 3'd2, 0, 0, 10'd100, 16'd700, 0);
        keys4(1, 2, 3, 4); enter();
        want("t6_amount", 3'd3, 0, 0, 10'd100, 16'd700, 0);
        key(1); key(3); key(0);
        want("t6_idle_nodebit", 3'd0, 0, 0, 10'd100, 16'd700, 0);
        card_in = 1'b0; tick();

        // Three wrong PINs -> lockout, then reset.
        want("t3_pin", 3'd1, 0, 0, 10'd100, 16'd700, 0);
        card_in = 1'b1; tick();
        for (int i = 0; i < 2; i++) begin
            want("t3_flash_on", 3'd1, 1, 0, 10'd100, 16'd700, 0);
            want("t3_flash_off", 3'd1, 0, 0, 10'd100, 16'd700, 0);
            keys4(1, 1, 1, 1); enter(); tick();
        end
        want("t3_locked", 3'd7, 1, 0, 10'd100, 16'd700, 0);
        keys4(1, 1, 1, 1); enter();
        repeat (5) tick();
        card_in = 1'b0;
        repeat (3) tick();
        want("t3_reset", 3'd0, 0, 0, 10'd0, 16'd1000, 0);
        reset = 1'b1; repeat (2) tick();
        reset = 1'b0; tick();

        // Inputs other than ack ignored in DISPENSE.
        want("di_pin", 3'd1, 0, 0, 10'd0, 16'd1000, 0);
        card_in = 1'b1; tick();
        want("di_menu", 3'd2, 0, 0, 10'd0, 16'd1000, 0);
        keys4(1, 2, 3, 4); enter();
        want("di_amount", 3'd3, 0, 0, 10'd0, 16'd1000, 0);
        key(1); key(3); key(0); key(0);
        want("di_dispense", 3'd4, 0, 1, 10'd300, 16'd700, 0);
        enter();
        card_in = 1'b0; cancel(); key(5); repeat (3) tick();
        want("di_eject", 3'd5, 0, 0, 10'd300, 16'd700, 1);
        want("di_idle", 3'd0, 0, 0, 10'd300, 16'd700, 0);
        ack(); tick();

        // Reset in the middle of AMOUNT.
        want("t1_pin", 3'd1, 0, 0, 10'd300, 16'd700, 0);
        card_in = 1'b1; tick();
        want("t1_menu", 3'd2, 0, 0, 10'd300, 16'd700, 0);
        keys4(1, 2, 3, 4); enter();
        want("t1_amount", 3'd3, 0, 0, 10'd300, 16'd700, 0);
        key(1); key(4);
        want("t1_reset", 3'd0, 0, 0, 10'd0, 16'd1000, 0);
        card_in = 1'b0; reset = 1'b1; repeat (2) tick();
        reset = 1'b0; tick();

        // Idle timeout in PIN: EJECT exactly TIMEOUT_CYC edges after entry.
        want("t5b_pin", 3'd1, 0, 0, 10'd0, 16'd1000, 0);
        card_in = 1'b1; tick();
        want("t5b_timeout_eject", 3'd5, 0, 0, 10'd0, 16'd1000, 1, cyc + 1000);
        repeat (1003) tick();
        want("t5b_idle", 3'd0, 0, 0, 10'd0, 16'd1000, 0);
        card_in = 1'b0; tick();

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected changes never seen, next is %s",
                     exp_q.size(), exp_q[0].name);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
